// File: rtl/mapper_context_loader_if.sv
// ---------------------------------------------------------------------------
// mapper_context_loader_if
// Groups the two buses of the context loader:
//   CPU register window : cs, rw, addr[1:0], data_in[7:0] -> data_out[7:0]
//   Mapper programming  : mm_cs, mm_rw, mm_rs[3:0], mm_wdata[11:0],
//                         mm_rdata[11:0] (from the mapper), mm_mode_cs,
//                         mm_mode_data[11:0]
//   Status              : busy
// slave  : the loader's view of the bundle.
// master : the view of whoever drives the CPU side and models the mapper.
// ---------------------------------------------------------------------------
interface mapper_context_loader_if;
  logic        cs;
  logic        rw;
  logic [1:0]  addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        mm_cs;
  logic        mm_rw;
  logic [3:0]  mm_rs;
  logic [11:0] mm_wdata;
  logic [11:0] mm_rdata;
  logic        mm_mode_cs;
  logic [11:0] mm_mode_data;
  logic        busy;

  modport slave (
    input  cs, rw, addr, data_in, mm_rdata,
    output data_out, mm_cs, mm_rw, mm_rs, mm_wdata, mm_mode_cs, mm_mode_data, busy
  );

  modport master (
    output cs, rw, addr, data_in, mm_rdata,
    input  data_out, mm_cs, mm_rw, mm_rs, mm_wdata, mm_mode_cs, mm_mode_data, busy
  );
endinterface

// File: rtl/mapper_context_loader.sv
// ---------------------------------------------------------------------------
// mapper_context_loader
// Holds NUM_CTX shadow contexts of 16 x 12-bit page entries, filled by the
// CPU through a 4-register byte window, and on command either LOADs a
// context into the mapper register file (16 back-to-back writes, optionally
// followed by one mode-register write enabling mapping) or SAVEs the live
// mapper registers back into a context (16 pipelined reads).
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : slave modport of mapper_context_loader_if (CPU window, mapper
//          programming strobes, busy)
// ---------------------------------------------------------------------------
module mapper_context_loader #(
  parameter int NUM_CTX = 4
) (
  input logic                   clk,
  input logic                   rst,
  mapper_context_loader_if.slave bus
);
  localparam int CTX_W = $clog2(NUM_CTX);
  localparam int AW    = CTX_W + 4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SAVE_RD, S_SAVE_LAST, S_ENABLE, S_FIN
  } state_t;

  state_t           r_state, w_state_next;
  logic [3:0]       r_i;
  logic [CTX_W-1:0] r_ctx;
  logic             r_en;
  logic [5:0]       r_index;
  logic [7:0]       r_lo;
  logic             r_done;
  logic [7:0]       r_data_out;
  logic [11:0]      r_pref;
  logic [11:0]      r_mem [NUM_CTX*16];

  logic          w_idle, w_wr, w_rd, w_start, w_commit;
  logic [AW-1:0] w_cpu_addr, w_pref_addr, w_mem_waddr;
  logic          w_mem_we;
  logic [11:0]   w_mem_wdata, w_cpu_rd;

  assign w_idle     = (r_state == S_IDLE);
  assign w_wr       = bus.cs & ~bus.rw;
  assign w_rd       = bus.cs & bus.rw;
  assign w_start    = w_wr && (bus.addr == 2'd0) && bus.data_in[7] && w_idle;
  // Table commits are dropped while a sequence owns the table.
  assign w_commit   = w_wr && (bus.addr == 2'd3) && w_idle;
  assign w_cpu_addr = {r_index[4 +: CTX_W], r_index[3:0]};
  assign w_cpu_rd   = r_mem[w_cpu_addr];

  // Prefetch one entry ahead so LOAD strobes run without gaps: on the start
  // edge fetch entry 0, then entry i+1 while entry i is being written out.
  assign w_pref_addr = w_idle ? {bus.data_in[CTX_W-1:0], 4'd0}
                              : {r_ctx, 4'(r_i + 4'd1)};

  // Table write port: CPU commits when idle, SAVE captures when sequencing.
  // Read data for strobe i arrives during strobe i+1, hence entry i-1; in
  // SAVE_LAST the counter has wrapped to 0 so i-1 lands on entry 15.
  always_comb begin
    w_mem_we    = w_commit;
    w_mem_waddr = w_cpu_addr;
    w_mem_wdata = {bus.data_in[3:0], r_lo};
    if ((r_state == S_SAVE_RD && r_i != 4'd0) || r_state == S_SAVE_LAST) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = {r_ctx, 4'(r_i - 4'd1)};
      w_mem_wdata = bus.mm_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
    r_pref <= r_mem[w_pref_addr];
  end

  // FSM: state register and sequence counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_i     <= 4'd0;
      r_ctx   <= '0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_i   <= 4'd0;
        r_ctx <= bus.data_in[CTX_W-1:0];
        r_en  <= bus.data_in[5];
      end else if (r_state == S_LOAD || r_state == S_SAVE_RD) begin
        r_i <= 4'(r_i + 4'd1);
      end
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_start) w_state_next = bus.data_in[6] ? S_SAVE_RD : S_LOAD;
      S_LOAD:      if (r_i == 4'd15) w_state_next = r_en ? S_ENABLE : S_FIN;
      S_SAVE_RD:   if (r_i == 4'd15) w_state_next = S_SAVE_LAST;
      S_SAVE_LAST: w_state_next = S_FIN;
      S_ENABLE:    w_state_next = S_FIN;
      S_FIN:       w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs (pure function of state, so all strobes drop on reset)
  always_comb begin
    bus.busy         = ~w_idle;
    bus.mm_cs        = (r_state == S_LOAD) || (r_state == S_SAVE_RD);
    bus.mm_rw        = (r_state == S_SAVE_RD);
    bus.mm_rs        = bus.mm_cs ? r_i : 4'd0;
    bus.mm_wdata     = (r_state == S_LOAD) ? r_pref : 12'd0;
    bus.mm_mode_cs   = (r_state == S_ENABLE);
    bus.mm_mode_data = (r_state == S_ENABLE) ? 12'h001 : 12'd0;
    bus.data_out     = r_data_out;
  end

  // CPU register window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_index    <= 6'd0;
      r_lo       <= 8'd0;
      r_done     <= 1'b0;
      r_data_out <= 8'd0;
    end else begin
      // Completion wins over a same-cycle STATUS read or CTRL write.
      if (r_state == S_FIN)
        r_done <= 1'b1;
      else if ((w_wr && bus.addr == 2'd0 && w_idle) || (w_rd && bus.addr == 2'd0))
        r_done <= 1'b0;

      if (w_wr && bus.addr == 2'd1) r_index <= bus.data_in[5:0];
      if (w_wr && bus.addr == 2'd2) r_lo <= bus.data_in;
      if (w_commit) r_index[3:0] <= 4'(r_index[3:0] + 4'd1);

      if (w_rd) begin
        case (bus.addr)
          2'd0: r_data_out <= {6'd0, r_done, ~w_idle};
          2'd1: r_data_out <= {2'd0, r_index};
          2'd2: r_data_out <= w_cpu_rd[7:0];
          default: r_data_out <= {4'd0, w_cpu_rd[11:8]};
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mapper_context_loader.sv
// ---------------------------------------------------------------------------
// tb_mapper_context_loader
// Directed + randomized bench for mapper_context_loader. Keeps a flat array
// model of the shadow table and predicts each sequence cycle from the
// published LOAD/SAVE timing; a small mapper model answers reads with
// rd_base + rs one cycle after each read strobe.
// ---------------------------------------------------------------------------
module tb_mapper_context_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mapper_context_loader_if bus ();
  mapper_context_loader #(.NUM_CTX(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [11:0] rd_base = 12'hA00;
  always @(posedge clk)
    bus.mm_rdata <= (bus.mm_cs && bus.mm_rw) ? 12'(rd_base + 12'(bus.mm_rs)) : 12'hFFF;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [11:0] model [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {bus.busy, bus.mm_cs, bus.mm_rw, bus.mm_rs, bus.mm_wdata,
            bus.mm_mode_cs, bus.mm_mode_data};
  endfunction

  // Expected {busy, mm_cs, mm_rw, mm_rs, mm_wdata, mm_mode_cs, mm_mode_data}
  // for cycle c after the start edge.
  function automatic logic [31:0] exp_vec(input bit dir, input bit en, input int ctx, input int c);
    int nb = (dir || en) ? 18 : 17;
    if (c >= nb) return 32'h0;
    if (c < 16) begin
      if (dir) return {1'b1, 1'b1, 1'b1, 4'(c), 12'h0, 1'b0, 12'h0};
      return {1'b1, 1'b1, 1'b0, 4'(c), model[ctx*16 + c], 1'b0, 12'h0};
    end
    if (!dir && en && c == 16) return {1'b1, 1'b0, 1'b0, 4'h0, 12'h0, 1'b1, 12'h001};
    return {1'b1, 31'h0};
  endfunction

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.rw = 1'b0; bus.addr = a; bus.data_in = d;
    @(posedge clk); #1;
    bus.cs = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    bus.cs = 1'b1; bus.rw = 1'b1; bus.addr = a;
    @(posedge clk); #1;
    bus.cs = 1'b0;
    d = bus.data_out;
  endtask

  task automatic prog_ctx(input int ctx, input bit rnd);
    logic [11:0] v;
    cpu_write(2'd1, {2'b00, 2'(ctx), 4'h0});
    for (int e = 0; e < 16; e++) begin
      v = rnd ? 12'($urandom) : 12'(12'h100 + e);
      cpu_write(2'd2, v[7:0]);
      cpu_write(2'd3, {4'h0, v[11:8]});
      model[ctx*16 + e] = v;
    end
  endtask

  task automatic check_entry(input int ctx, input int e);
    logic [7:0] lo, hi;
    cpu_write(2'd1, {2'b00, 2'(ctx), 4'(e)});
    cpu_read(2'd2, lo);
    cpu_read(2'd3, hi);
    check($sformatf("entry c%0d e%0d", ctx, e), {16'h0, hi, lo}, {20'h0, model[ctx*16 + e]});
  endtask

  task automatic check_status(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    cpu_read(2'd0, d);
    check(tag, {24'h0, d}, {24'h0, exp});
  endtask

  // Start a sequence and check every cycle. probe: cycle at which a STATUS
  // read is issued (-1 none); inj_*: cycles at which an extra CTRL write or
  // DATA_HI commit is attempted; abort: cycle during which rst is raised.
  task automatic run(input logic [7:0] ctrl, input int probe, input int inj_ctrl,
                     input int inj_hi, input int abort);
    bit dir = ctrl[6];
    bit en  = ctrl[5];
    int ctx = int'(ctrl[1:0]);
    int nb  = (ctrl[6] || ctrl[5]) ? 18 : 17;
    cpu_write(2'd0, ctrl);
    for (int c = 0; c <= nb; c++) begin
      bus.cs = 1'b0;
      if (probe >= 0 && c == probe + 1)
        check($sformatf("status_probe ctrl=%0h c=%0d", ctrl, c), {24'h0, bus.data_out}, 32'h01);
      if (c == probe)    begin bus.cs = 1'b1; bus.rw = 1'b1; bus.addr = 2'd0; end
      if (c == inj_ctrl) begin bus.cs = 1'b1; bus.rw = 1'b0; bus.addr = 2'd0; bus.data_in = 8'hC2; end
      if (c == inj_hi)   begin bus.cs = 1'b1; bus.rw = 1'b0; bus.addr = 2'd3; bus.data_in = 8'h0F; end
      check($sformatf("seq ctrl=%0h c=%0d", ctrl, c), obs_vec(), exp_vec(dir, en, ctx, c));
      if (c == abort) begin
        rst = 1'b1; bus.cs = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_outputs", obs_vec(), 32'h0);
        check_status("abort_status", 8'h00);
        return;
      end
      if (c < nb) begin @(posedge clk); #1; end
    end
    bus.cs = 1'b0;
    if (dir) for (int k = 0; k < 16; k++) model[ctx*16 + k] = 12'(rd_base + 12'(k));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [31:0] r;
    logic [7:0] ctrl;
    bus.cs = 1'b0; bus.rw = 1'b0; bus.addr = 2'd0; bus.data_in = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset_outputs", obs_vec(), 32'h0);
    check("reset_dout", {24'h0, bus.data_out}, 32'h0);
    check_status("reset_status", 8'h00);

    // 1: program ctx 1 with 0x100+i, entry wrap, readback
    prog_ctx(1, 1'b0);
    cpu_read(2'd1, d);
    check("index_wrap", {24'h0, d}, 32'h10);
    check_entry(1, 5);
    prog_ctx(0, 1'b1);
    prog_ctx(2, 1'b1);
    prog_ctx(3, 1'b1);

    // 2: load ctx 1 with enable
    run(8'hA1, -1, -1, -1, -1);
    check_status("load_done", 8'h02);
    check_status("load_done_cleared", 8'h00);

    // 3: save into ctx 2
    rd_base = 12'hA00;
    run(8'hC2, -1, -1, -1, -1);
    check_status("save_done", 8'h02);
    for (int e = 0; e < 16; e++) check_entry(2, e);

    // 4: CTRL write and DATA_HI commit while busy are ignored
    cpu_write(2'd1, 8'h33);
    cpu_write(2'd2, 8'h55);
    run(8'h80, -1, 3, 5, -1);
    cpu_read(2'd1, d);
    check("busy_commit_index", {24'h0, d}, 32'h33);
    check_status("busy_ignore_done", 8'h02);
    check_entry(3, 3);
    check_entry(2, 0);

    // 5: reset mid-LOAD, then a full LOAD with a STATUS read on the FIN cycle
    run(8'hA3, -1, -1, -1, 7);
    run(8'h83, 16, -1, -1, -1);
    check_status("fin_read_done", 8'h02);

    // 6: back-to-back start right after FIN
    rd_base = 12'($urandom);
    run(8'h80, -1, -1, -1, -1);
    run(8'hC1, 2, -1, -1, -1);
    check_status("b2b_done", 8'h02);
    check_entry(1, 0);
    check_entry(1, 7);
    check_entry(1, 15);

    // Randomized sequences (bits 4:2 of CTRL are don't-care)
    for (int it = 0; it < 6; it++) begin
      r = $urandom;
      ctrl = {1'b1, r[6], r[5], r[4:0]};
      if (ctrl[6]) rd_base = 12'($urandom);
      else prog_ctx(int'(ctrl[1:0]), 1'b1);
      run(ctrl, -1, -1, -1, -1);
      check_status($sformatf("rand_done it%0d", it), 8'h02);
      if (ctrl[6]) check_entry(int'(ctrl[1:0]), int'(r[11:8]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
